// File: rtl/screen_pkg.sv
// Shared geometry, default timing and pipeline constants for the Hack screen scanner.
// Optional inversion (SCREEN_SCAN_INVERT_EN) lives in screen_scanner.
package screen_pkg;

    localparam int SCREEN_W      = 512;
    localparam int SCREEN_H      = 256;
    localparam int WORDS_PER_ROW = 32;
    localparam int ADDR_W        = 13;
    localparam int DATA_W        = 16;

    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 64;
    localparam int H_BP_DEF   = 48;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic de;
        logic hsync_n;
        logic vsync_n;
        logic frame_start;
    } tctl_t;

    localparam tctl_t CTL_IDLE = '{de: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1, frame_start: 1'b0};

endpackage

// File: rtl/scan_timing.sv
// Raster counters plus active/sync/frame-start decode, all combinational from the counters.
// Zero latency: decode refers to the current counter position; never stalls.
module scan_timing
    import screen_pkg::*;
#(
    parameter int H_ACTIVE = SCREEN_W,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = SCREEN_H,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int HW       = 10,
    parameter int VW       = 9
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          active_o,
    output tctl_t         ctl_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          active;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (int'(h_cnt_q) == H_TOTAL - 1) begin
            h_cnt_d = '0;
            v_cnt_d = (int'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        active            = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
        ctl_o.de          = active;
        ctl_o.hsync_n     = !((int'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                              (int'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC));
        ctl_o.vsync_n     = !((int'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                              (int'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC));
        ctl_o.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    assign h_cnt_o  = h_cnt_q;
    assign v_cnt_o  = v_cnt_q;
    assign active_o = active;

endmodule

// File: rtl/screen_scanner.sv
// Hack screen read-out: address fetch, 1-clk memory wait, bit serialise; syncs delayed to match.
// Latency PIPE_LAT=3 clks counter->outputs; no backpressure. SCREEN_SCAN_INVERT_EN adds per-frame invert.
module screen_scanner
    import screen_pkg::*;
#(
    parameter int H_ACTIVE = SCREEN_W,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = SCREEN_H,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef SCREEN_SCAN_INVERT_EN
    input  logic              invert,
`endif
    output logic              pixel_out,
    output logic              de,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int WPR     = H_ACTIVE / 16;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active;
    tctl_t         ctl;

    scan_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW), .VW(VW)
    ) u_timing (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .h_cnt_o (h_cnt),
        .v_cnt_o (v_cnt),
        .active_o(active),
        .ctl_o   (ctl)
    );

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        hlo_d1_q, hlo_d2_q;
    tctl_t             ctl_d1_q, ctl_d2_q, ctl_q;
    logic              pixel_q, pixel_d;
    logic              inv;

`ifdef SCREEN_SCAN_INVERT_EN
    // Sampled only at counter (0,0) so a toggle never tears a frame.
    logic inv_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                inv_q <= 1'b0;
        else if (ctl.frame_start)  inv_q <= invert;
    end
    assign inv = inv_q;
`else
    assign inv = 1'b0;
`endif

    always_comb begin
        mem_addr_d = '0;
        if (active)
            mem_addr_d = ADDR_W'(int'(v_cnt) * WPR + int'(h_cnt) / 16);
        pixel_d = ctl_d2_q.de & (mem_rdata[hlo_d2_q] ^ inv);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q <= '0;
            hlo_d1_q   <= '0;
            hlo_d2_q   <= '0;
            ctl_d1_q   <= CTL_IDLE;
            ctl_d2_q   <= CTL_IDLE;
            ctl_q      <= CTL_IDLE;
            pixel_q    <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr_d;
            hlo_d1_q   <= h_cnt[3:0];
            hlo_d2_q   <= hlo_d1_q;
            ctl_d1_q   <= ctl;
            ctl_d2_q   <= ctl_d1_q;
            ctl_q      <= ctl_d2_q;
            pixel_q    <= pixel_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign pixel_out   = pixel_q;
    assign de          = ctl_q.de;
    assign hsync_n     = ctl_q.hsync_n;
    assign vsync_n     = ctl_q.vsync_n;
    assign frame_start = ctl_q.frame_start;

endmodule

// File: tb/tb_screen_scanner.sv
// Two scanners (default geometry and a tiny one for full-frame coverage) against a position-based model.
module tb_screen_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n = 1'b0;
    logic        rst_b_n = 1'b0;
    logic        invert_b = 1'b0;

    logic [12:0] mem_addr_a, mem_addr_b;
    logic [15:0] mem_rdata_a, mem_rdata_b;
    logic        pix_a, de_a, hs_a, vs_a, fs_a;
    logic        pix_b, de_b, hs_b, vs_b, fs_b;

    logic [15:0] mem_a [0:8191];
    logic [15:0] mem_b [0:8191];
    logic        inv_hist_b [0:63];

    int tests = 0;
    int fails = 0;
    int na = 0;
    int nb = 0;

    always @(posedge clk) mem_rdata_a <= mem_a[mem_addr_a];
    always @(posedge clk) mem_rdata_b <= mem_b[mem_addr_b];

    screen_scanner u_a (
        .clk(clk), .rst_n(rst_a_n), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a),
`ifdef SCREEN_SCAN_INVERT_EN
        .invert(1'b0),
`endif
        .pixel_out(pix_a), .de(de_a), .hsync_n(hs_a), .vsync_n(vs_a), .frame_start(fs_a)
    );

    screen_scanner #(
        .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2)
    ) u_b (
        .clk(clk), .rst_n(rst_b_n), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
`ifdef SCREEN_SCAN_INVERT_EN
        .invert(invert_b),
`endif
        .pixel_out(pix_b), .de(de_b), .hsync_n(hs_b), .vsync_n(vs_b), .frame_start(fs_b)
    );

    // n = clocks since reset release; outputs show position n-3, mem_addr shows position n-1.
    task automatic chk(input string tag, input int which, input int n,
                       input int ha, input int hfp, input int hs, input int hb,
                       input int va, input int vfp, input int vs, input int vb,
                       input logic [12:0] addr, input logic pix, input logic de,
                       input logic hsn, input logic vsn, input logic fs);
        int ht, vt, p, h, v, f, idx;
        logic [12:0] e_addr;
        logic [15:0] w;
        logic e_pix, e_de, e_hs, e_vs, e_fs, act, inv;
        ht = ha + hfp + hs + hb;
        vt = va + vfp + vs + vb;
        e_addr = '0;
        if (n >= 1) begin
            p = n - 1;
            h = p % ht;
            v = (p / ht) % vt;
            if (h < ha && v < va) e_addr = 13'(v * (ha / 16) + h / 16);
        end
        e_pix = 1'b0; e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
        if (n >= 3) begin
            p = n - 3;
            h = p % ht;
            v = (p / ht) % vt;
            f = p / (ht * vt);
            act = (h < ha) && (v < va);
            idx = v * (ha / 16) + h / 16;
            w = (which == 1) ? mem_b[idx % 8192] : mem_a[idx % 8192];
            inv = (which == 1) ? inv_hist_b[f % 64] : 1'b0;
            e_de = act;
            e_pix = act ? (w[h % 16] ^ inv) : 1'b0;
            e_hs = !(h >= ha + hfp && h < ha + hfp + hs);
            e_vs = !(v >= va + vfp && v < va + vfp + vs);
            e_fs = (h == 0) && (v == 0);
        end
        tests++;
        assert (addr === e_addr) else begin
            fails++; $error("FAIL %s mem_addr n=%0d got %0d exp %0d", tag, n, addr, e_addr);
        end
        tests++;
        assert (pix === e_pix) else begin
            fails++; $error("FAIL %s pixel_out n=%0d got %b exp %b", tag, n, pix, e_pix);
        end
        tests++;
        assert (de === e_de) else begin
            fails++; $error("FAIL %s de n=%0d got %b exp %b", tag, n, de, e_de);
        end
        tests++;
        assert (hsn === e_hs) else begin
            fails++; $error("FAIL %s hsync_n n=%0d got %b exp %b", tag, n, hsn, e_hs);
        end
        tests++;
        assert (vsn === e_vs) else begin
            fails++; $error("FAIL %s vsync_n n=%0d got %b exp %b", tag, n, vsn, e_vs);
        end
        tests++;
        assert (fs === e_fs) else begin
            fails++; $error("FAIL %s frame_start n=%0d got %b exp %b", tag, n, fs, e_fs);
        end
    endtask

    task automatic chk_a(input string tag);
        chk(tag, 0, na, 512, 16, 64, 48, 256, 10, 2, 33,
            mem_addr_a, pix_a, de_a, hs_a, vs_a, fs_a);
    endtask

    task automatic chk_b(input string tag);
        chk(tag, 1, nb, 32, 2, 4, 3, 4, 1, 1, 2,
            mem_addr_b, pix_b, de_b, hs_b, vs_b, fs_b);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_a_n) na++;
        if (rst_b_n) nb++;
        @(negedge clk);
        if (rst_b_n && (nb % 328 == 0)) inv_hist_b[(nb / 328) % 64] = invert_b;
        chk_a("dflt");
        chk_b("tiny");
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem_a[i] = (i < 32) ? 16'h0000 : 16'($urandom);
            mem_b[i] = 16'($urandom);
        end
        mem_a[0] = 16'h0001;
        mem_a[1] = 16'h8000;
        for (int i = 0; i < 64; i++) inv_hist_b[i] = 1'b0;

        repeat (3) tick();
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // Tiny DUT reaches v=2,h=10 here; hit it with an asynchronous reset mid-frame.
        repeat (92) tick();
        #1 rst_b_n = 1'b0;
        nb = 0;
        #1 chk_b("async_rst");
        repeat (5) tick();
        rst_b_n = 1'b1;

        repeat (400) tick();
`ifdef SCREEN_SCAN_INVERT_EN
        invert_b = 1'b1;
`endif
        repeat (1450) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
